// File: rtl/ex_mem_pipe_reg_if.sv
// ex_mem_pipe_reg_if: EX-side and MEM-side handshake/data bundle for the EX->MEM pipeline register.
// The slave modport is the pipeline register's view; master is the surrounding pipeline's view.
interface ex_mem_pipe_reg_if #(
    parameter int XLEN = 64,
    parameter int RAW  = 5,
    parameter int F3W  = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] alu_result_in;
    logic [XLEN-1:0] store_data_in;
    logic [5:0]      ctrl_in;
    logic [RAW-1:0]  rd_in;
    logic [F3W-1:0]  funct3_in;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result_out;
    logic [XLEN-1:0] store_data_out;
    logic [5:0]      ctrl_out;
    logic [RAW-1:0]  rd_out;
    logic [F3W-1:0]  funct3_out;

    modport slave (
        input  in_valid, alu_result_in, store_data_in, ctrl_in, rd_in, funct3_in, out_ready,
        output in_ready, out_valid, alu_result_out, store_data_out, ctrl_out, rd_out, funct3_out
    );

    modport master (
        output in_valid, alu_result_in, store_data_in, ctrl_in, rd_in, funct3_in, out_ready,
        input  in_ready, out_valid, alu_result_out, store_data_out, ctrl_out, rd_out, funct3_out
    );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX->MEM stage register with valid/ready handshake, 2-entry skid buffer and flush.
// Define EX_MEM_STALL_CNT_EN to add the saturating stall_cnt output.
module ex_mem_pipe_reg #(
    parameter int XLEN = 64,
    parameter int RAW  = 5,
    parameter int F3W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    ex_mem_pipe_reg_if.slave      bus
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] sd;
        logic [5:0]      ctrl;
        logic [RAW-1:0]  rd;
        logic [F3W-1:0]  f3;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   accept;
    logic   drain;

    assign in_entry = {bus.alu_result_in, bus.store_data_in, bus.ctrl_in, bus.rd_in, bus.funct3_in};

    // Ready is decoded from registered occupancy only, so MEM stalls never reach EX combinationally.
    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign accept        = bus.in_valid & (state_q != FULL);
    assign drain         = bus.out_ready & (state_q != EMPTY);

    assign bus.alu_result_out = main_q.alu;
    assign bus.store_data_out = main_q.sd;
    assign bus.rd_out         = main_q.rd;
    assign bus.funct3_out     = main_q.f3;
    assign bus.ctrl_out       = (state_q != EMPTY) ? main_q.ctrl : 6'b0;

    always_comb begin
        // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d     = EMPTY;
            main_d.ctrl = 6'b0;
            skid_d.ctrl = 6'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = FULL;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: both data entries are reset too, so no output field can carry X out of reset.
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Counts MEM back-pressure cycles; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if ((state_q != EMPTY) && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: scoreboard bench for the EX->MEM pipeline register.
// Expected entries are queued on every accepted input and popped on every MEM-side transfer.
module tb_ex_mem_pipe_reg;
    localparam int XLEN = 64;
    localparam int RAW  = 5;
    localparam int F3W  = 3;

    typedef struct packed {
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] sd;
        logic [5:0]      ctrl;
        logic [RAW-1:0]  rd;
        logic [F3W-1:0]  f3;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    ex_mem_pipe_reg_if #(.XLEN(XLEN), .RAW(RAW), .F3W(F3W)) bus ();

`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    ex_mem_pipe_reg #(.XLEN(XLEN), .RAW(RAW), .F3W(F3W)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .bus      (bus)
`ifdef EX_MEM_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    int     total = 0;
    int     bad   = 0;
    int     drained = 0;
    entry_t sb_q[$];

    function automatic entry_t mk(input int n, input logic [5:0] c);
        entry_t e;
        e.alu  = XLEN'(n);
        e.sd   = ~XLEN'(n);
        e.ctrl = c;
        e.rd   = RAW'(n);
        e.f3   = F3W'(n);
        return e;
    endfunction

    task automatic set_in(input logic v, input entry_t e);
        bus.in_valid      = v;
        bus.alu_result_in = e.alu;
        bus.store_data_in = e.sd;
        bus.ctrl_in       = e.ctrl;
        bus.rd_in         = e.rd;
        bus.funct3_in     = e.f3;
    endtask

    // One clock: scoreboard bookkeeping at the falling edge, then advance past the rising edge.
    task automatic cycle();
        entry_t exp_e;
        entry_t obs_e;
        @(negedge clk);
        if (reset) begin
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                obs_e = {bus.alu_result_out, bus.store_data_out, bus.ctrl_out, bus.rd_out, bus.funct3_out};
                total++;
                drained++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got alu=%h ctrl=%b, required no output", obs_e.alu, obs_e.ctrl);
                end else begin
                    exp_e = sb_q.pop_front();
                    if (obs_e !== exp_e) begin
                        bad++;
                        $display("FAIL sb_order: got alu=%h sd=%h ctrl=%b rd=%0d f3=%0d, required alu=%h sd=%h ctrl=%b rd=%0d f3=%0d",
                                 obs_e.alu, obs_e.sd, obs_e.ctrl, obs_e.rd, obs_e.f3,
                                 exp_e.alu, exp_e.sd, exp_e.ctrl, exp_e.rd, exp_e.f3);
                    end
                end
            end
            if (bus.out_valid === 1'b0) begin
                total++;
                if (bus.ctrl_out !== 6'b0) begin
                    bad++;
                    $display("FAIL bubble_ctrl: got %b, required 000000", bus.ctrl_out);
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (bus.in_valid && bus.in_ready === 1'b1) begin
                sb_q.push_back({bus.alu_result_in, bus.store_data_in, bus.ctrl_in, bus.rd_in, bus.funct3_in});
            end
        end else begin
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        set_in(1'b1, mk(32'h5A5A, 6'b111111));
        do_reset();
        set_in(1'b0, mk(0, 6'b0));
        total++;
        if (bus.out_valid !== 1'b0 || bus.ctrl_out !== 6'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ctrl: got out_valid=%b ctrl=%b in_ready=%b, required 0 000000 1",
                     bus.out_valid, bus.ctrl_out, bus.in_ready);
        end
        total++;
        if (bus.alu_result_out !== '0 || bus.store_data_out !== '0 || bus.rd_out !== '0 || bus.funct3_out !== '0) begin
            bad++;
            $display("FAIL reset_data: got alu=%h sd=%h rd=%0d f3=%0d, required all 0",
                     bus.alu_result_out, bus.store_data_out, bus.rd_out, bus.funct3_out);
        end
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, mk(i, 6'b011010));
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_in_ready: got %b, required 1 (i=%0d)", bus.in_ready, i);
            end
            cycle();
            total++;
            if (bus.out_valid !== 1'b1 || bus.alu_result_out !== XLEN'(i)) begin
                bad++;
                $display("FAIL stream_out: got valid=%b alu=%0d, required valid=1 alu=%0d",
                         bus.out_valid, bus.alu_result_out, i);
            end
        end
        set_in(1'b0, mk(0, 6'b0));
        cycle();
        total++;
        if (bus.out_valid !== 1'b0 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL stream_drain: got valid=%b pending=%0d, required 0 0", bus.out_valid, sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        int start;
        start         = drained;
        bus.out_ready = 1'b0;
        set_in(1'b1, mk(32'hA, 6'b000110));
        cycle();
        set_in(1'b1, mk(32'hB, 6'b000110));
        cycle();
        set_in(1'b1, mk(32'hC, 6'b000110));
        total++;
        if (bus.in_ready !== 1'b0 || bus.alu_result_out !== XLEN'(32'hA)) begin
            bad++;
            $display("FAIL skid_full: got in_ready=%b alu=%h, required 0 a", bus.in_ready, bus.alu_result_out);
        end
        cycle();
        cycle();
        total++;
        if (bus.in_ready !== 1'b0 || sb_q.size() != 2) begin
            bad++;
            $display("FAIL skid_hold: got in_ready=%b queued=%0d, required 0 2", bus.in_ready, sb_q.size());
        end
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        set_in(1'b0, mk(0, 6'b0));
        cycle();
        cycle();
        total++;
        if (drained - start != 3 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL skid_drain: got drained=%0d valid=%b, required 3 0", drained - start, bus.out_valid);
        end
    endtask

    task automatic test_flush_full();
        bus.out_ready = 1'b0;
        set_in(1'b1, mk(32'hD, 6'b000010));
        cycle();
        set_in(1'b1, mk(32'hE, 6'b000010));
        cycle();
        total++;
        if (bus.in_ready !== 1'b0 || bus.ctrl_out !== 6'b000010) begin
            bad++;
            $display("FAIL flush_pre: got in_ready=%b ctrl=%b, required 0 000010", bus.in_ready, bus.ctrl_out);
        end
        flush = 1'b1;
        set_in(1'b1, mk(32'hF, 6'b000010));
        cycle();
        flush = 1'b0;
        set_in(1'b0, mk(0, 6'b0));
        total++;
        if (bus.out_valid !== 1'b0 || bus.ctrl_out !== 6'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_state: got valid=%b ctrl=%b in_ready=%b, required 0 000000 1",
                     bus.out_valid, bus.ctrl_out, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_ghost: got valid=%b alu=%h, required valid 0", bus.out_valid, bus.alu_result_out);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        set_in(1'b1, mk(32'h11, 6'b011010));
        cycle();
        set_in(1'b1, mk(32'h12, 6'b011010));
        cycle();
        set_in(1'b1, mk(32'h13, 6'b011010));
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        set_in(1'b0, mk(0, 6'b0));
        total++;
        if (bus.out_valid !== 1'b0 || bus.ctrl_out !== 6'b0 || bus.alu_result_out !== '0 ||
            bus.store_data_out !== '0 || bus.rd_out !== '0 || bus.funct3_out !== '0) begin
            bad++;
            $display("FAIL rstmid_clear: got valid=%b ctrl=%b alu=%h sd=%h rd=%0d f3=%0d, required all 0",
                     bus.out_valid, bus.ctrl_out, bus.alu_result_out, bus.store_data_out, bus.rd_out, bus.funct3_out);
        end
        set_in(1'b1, mk(32'h14, 6'b001010));
        cycle();
        set_in(1'b0, mk(0, 6'b0));
        total++;
        if (bus.out_valid !== 1'b1 || bus.alu_result_out !== XLEN'(32'h14)) begin
            bad++;
            $display("FAIL rstmid_latency: got valid=%b alu=%h, required 1 14", bus.out_valid, bus.alu_result_out);
        end
        bus.out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_accept_drain();
        bus.out_ready = 1'b0;
        set_in(1'b1, mk(5, 6'b100001));
        cycle();
        bus.out_ready = 1'b1;
        set_in(1'b1, mk(6, 6'b100001));
        cycle();
        set_in(1'b0, mk(0, 6'b0));
        total++;
        if (bus.out_valid !== 1'b1 || bus.alu_result_out !== XLEN'(6) || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_drain: got valid=%b alu=%0d in_ready=%b, required 1 6 1",
                     bus.out_valid, bus.alu_result_out, bus.in_ready);
        end
        cycle();
        total++;
        if (sb_q.size() != 0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL accept_drain_end: got pending=%0d valid=%b, required 0 0", sb_q.size(), bus.out_valid);
        end
    endtask

`ifdef EX_MEM_STALL_CNT_EN
    task automatic test_stall_cnt();
        set_in(1'b0, mk(0, 6'b0));
        do_reset();
        total++;
        if (stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL stall_reset: got %0d, required 0", stall_cnt);
        end
        bus.out_ready = 1'b0;
        set_in(1'b1, mk(32'h21, 6'b000010));
        cycle();
        set_in(1'b0, mk(0, 6'b0));
        for (int i = 0; i < 7; i++) cycle();
        total++;
        if (stall_cnt !== 32'd7) begin
            bad++;
            $display("FAIL stall_count: got %0d, required 7", stall_cnt);
        end
        bus.out_ready = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        total++;
        if (stall_cnt !== 32'd7) begin
            bad++;
            $display("FAIL stall_flush: got %0d, required 7", stall_cnt);
        end
        do_reset();
        total++;
        if (stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL stall_clear: got %0d, required 0", stall_cnt);
        end
    endtask
`endif

    initial begin
        reset         = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b0, mk(0, 6'b0));
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_reset_mid();
        test_accept_drain();
`ifdef EX_MEM_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
